// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch direction predictor: table geometry,
// counter encodings and the controller state type.
package gshare_predictor_pkg;

    localparam int GHR_SIZE           = 8;
    localparam int COUNTER_TABLE_SZ   = 1024;
    localparam int COUNTER_BITS       = 2;
    localparam int COUNTER_TABLE_BITS = $clog2(COUNTER_TABLE_SZ);

    typedef enum logic [COUNTER_BITS-1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } cntr_pattern_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pred_state_t;

endpackage

// File: rtl/gshare_predictor_pht_ram.sv
// Pattern history table storage: registered lookup read with read-old-data on
// collision, one write port, and a combinational tap feeding the update adder.
module pht_ram
    import gshare_predictor_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output cntr_pattern_t       rd_data,
    input  logic [ADDR_W-1:0]   rmw_addr,
    output cntr_pattern_t       rmw_data,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  cntr_pattern_t       wr_data
);

    cntr_pattern_t mem [DEPTH];

    // Both accesses sit in one process so a same-address read sees the old value.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rmw_data = mem[rmw_addr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit
// saturating counters; history and counters are trained only at branch resolve.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int GHR_SIZE             = gshare_predictor_pkg::GHR_SIZE,
    parameter int COUNTER_TABLE_SZ     = gshare_predictor_pkg::COUNTER_TABLE_SZ,
    localparam int COUNTER_TABLE_BITS  = $clog2(COUNTER_TABLE_SZ)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          ready_o,
    input  logic                          pred_valid_i,
    input  logic [31:0]                   pred_pc_i,
    output logic                          pred_valid_o,
    output logic                          pred_taken_o,
    output logic [COUNTER_TABLE_BITS-1:0] pred_idx_o,
    input  logic                          upd_valid_i,
    input  logic [COUNTER_TABLE_BITS-1:0] upd_idx_i,
    input  logic                          upd_taken_i,
    output logic [GHR_SIZE-1:0]           ghr_o
);

    localparam int CTB = COUNTER_TABLE_BITS;

    function automatic cntr_pattern_t sat_update(input cntr_pattern_t cur, input logic taken);
        cntr_pattern_t res;
        res = cur;
        if (taken && cur != STRONGLY_TAKEN) begin
            res = cntr_pattern_t'(cur + 2'd1);
        end else if (!taken && cur != STRONGLY_NOT_TAKEN) begin
            res = cntr_pattern_t'(cur - 2'd1);
        end
        return res;
    endfunction

    pred_state_t   state, state_nxt;
    logic [CTB-1:0] sweep_idx;
    logic [GHR_SIZE-1:0] ghr;
    logic          run;
    logic          lookup_p0, upd_p0;
    logic [CTB-1:0] idx_p0;
    logic          vld_p1;
    logic [CTB-1:0] idx_p1;
    logic          taken_hold;
    cntr_pattern_t rd_data, rmw_data, wr_data;
    logic          wr_en;
    logic [CTB-1:0] wr_addr;
    logic          unused_pc;

    assign run       = (state == ST_RUN);
    assign lookup_p0 = pred_valid_i & run;
    assign upd_p0    = upd_valid_i & run;
    assign idx_p0    = pred_pc_i[CTB+1:2] ^ CTB'(ghr);
    assign unused_pc = ^{pred_pc_i[31:CTB+2], pred_pc_i[1:0]};

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && sweep_idx == CTB'(COUNTER_TABLE_SZ - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    // The init sweep and resolved-branch training share the single write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sweep_idx;
        wr_data = WEAKLY_NOT_TAKEN;
        if (!rst) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (upd_p0) begin
                wr_en   = 1'b1;
                wr_addr = upd_idx_i;
                wr_data = sat_update(rmw_data, upd_taken_i);
            end
        end
    end

    pht_ram #(
        .DEPTH  (COUNTER_TABLE_SZ),
        .ADDR_W (CTB)
    ) u_pht (
        .clk      (clk),
        .rd_en    (lookup_p0),
        .rd_addr  (idx_p0),
        .rd_data  (rd_data),
        .rmw_addr (upd_idx_i),
        .rmw_data (rmw_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    // Stage p0 -> p1: lookup result, history is non-speculative.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            idx_p1     <= '0;
            taken_hold <= 1'b0;
            ghr        <= '0;
        end else begin
            vld_p1 <= lookup_p0;
            if (lookup_p0) begin
                idx_p1 <= idx_p0;
            end
            if (vld_p1) begin
                taken_hold <= rd_data[1];
            end
            if (upd_p0) begin
                ghr <= {ghr[GHR_SIZE-2:0], upd_taken_i};
            end
        end
    end

    assign ready_o      = run;
    assign pred_valid_o = vld_p1;
    assign pred_taken_o = vld_p1 ? rd_data[1] : taken_hold;
    assign pred_idx_o   = idx_p1;
    assign ghr_o        = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gshare_predictor;

    localparam int SZ  = 1024;
    localparam int CTB = 10;
    localparam int GS  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           ready_o;
    logic           pred_valid_i;
    logic [31:0]    pred_pc_i;
    logic           pred_valid_o;
    logic           pred_taken_o;
    logic [CTB-1:0] pred_idx_o;
    logic           upd_valid_i;
    logic [CTB-1:0] upd_idx_i;
    logic           upd_taken_i;
    logic [GS-1:0]  ghr_o;

    gshare_predictor #(.GHR_SIZE(GS), .COUNTER_TABLE_SZ(SZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_o      (ready_o),
        .pred_valid_i (pred_valid_i),
        .pred_pc_i    (pred_pc_i),
        .pred_valid_o (pred_valid_o),
        .pred_taken_o (pred_taken_o),
        .pred_idx_o   (pred_idx_o),
        .upd_valid_i  (upd_valid_i),
        .upd_idx_i    (upd_idx_i),
        .upd_taken_i  (upd_taken_i),
        .ghr_o        (ghr_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as integers 0..3, history as an integer mod 2^GS.
    int  mcnt [SZ];
    int  mghr;
    int  minit;
    int  li;
    bit  mrun;
    bit  armed;
    bit  exp_valid;
    bit  exp_taken;
    int  exp_idx;
    int  taken_seen;
    int  valid_seen;

    initial begin
        for (int i = 0; i < SZ; i++) mcnt[i] = -1;
        armed = 0; mrun = 0; minit = 0; mghr = 0;
        exp_valid = 0; exp_taken = 0; exp_idx = 0;
        taken_seen = 0; valid_seen = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            armed = 1; mrun = 0; minit = 0; mghr = 0;
            exp_valid = 0; exp_taken = 0; exp_idx = 0;
        end else if (!mrun) begin
            mcnt[minit] = 1;
            minit++;
            if (minit == SZ) mrun = 1;
            exp_valid = 0;
        end else begin
            if (pred_valid_i) begin
                li = int'((pred_pc_i >> 2) % SZ) ^ mghr;
                exp_valid = 1;
                exp_taken = (mcnt[li] >= 2);
                exp_idx   = li;
            end else begin
                exp_valid = 0;
            end
            if (upd_valid_i) begin
                if (upd_taken_i) mcnt[upd_idx_i] = (mcnt[upd_idx_i] == 3) ? 3 : mcnt[upd_idx_i] + 1;
                else             mcnt[upd_idx_i] = (mcnt[upd_idx_i] == 0) ? 0 : mcnt[upd_idx_i] - 1;
                mghr = ((mghr << 1) | int'(upd_taken_i)) % (1 << GS);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ready_o",      ready_o,      mrun);
            chk("pred_valid_o", pred_valid_o, exp_valid);
            chk("ghr_o",        ghr_o,        mghr);
            chk("pred_taken_o", pred_taken_o, exp_taken);
            chk("pred_idx_o",   pred_idx_o,   exp_idx);
            if (pred_valid_o && pred_taken_o) taken_seen++;
            if (pred_valid_o) valid_seen++;
        end
    end

    task automatic step(input bit pv, input logic [31:0] pc, input bit uv,
                        input logic [CTB-1:0] ui, input bit ut);
        pred_valid_i = pv;
        pred_pc_i    = pc;
        upd_valid_i  = uv;
        upd_idx_i    = ui;
        upd_taken_i  = ut;
        @(negedge clk);
        pred_valid_i = 1'b0;
        upd_valid_i  = 1'b0;
    endtask

    // Counts negedges with ready_o low, starting at the reset-release negedge.
    task automatic wait_ready(input bit noisy, output int n);
        n = 0;
        while (!ready_o && n < 3000) begin
            if (noisy && n < 20) begin
                pred_valid_i = 1'b1; pred_pc_i = n * 4;
                upd_valid_i  = 1'b1; upd_idx_i = CTB'(n); upd_taken_i = 1'b1;
            end else begin
                pred_valid_i = 1'b0; upd_valid_i = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        pred_valid_i = 1'b0;
        upd_valid_i  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n;

    initial begin
        rst = 1'b1;
        pred_valid_i = 1'b0; pred_pc_i = '0;
        upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready_o",      ready_o,      0);
        chk("rst pred_valid_o", pred_valid_o, 0);
        chk("rst pred_taken_o", pred_taken_o, 0);
        chk("rst pred_idx_o",   pred_idx_o,   0);
        chk("rst ghr_o",        ghr_o,        0);
        rst = 1'b0;

        // Requests during the sweep must be ignored.
        valid_seen = 0;
        wait_ready(1'b1, n);
        chk("init ready latency", n, 1024);
        chk("init no pred_valid_o", valid_seen, 0);
        chk("init ghr untouched", ghr_o, 0);

        // Every table entry starts weakly not-taken.
        @(negedge clk);
        taken_seen = 0; valid_seen = 0;
        for (int i = 0; i < SZ; i++) step(1'b1, i * 4, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("sweep all not-taken", taken_seen, 0);
        chk("sweep lookup count", valid_seen, 1024);

        // Reset in the middle of a sweep restarts it from index 0.
        pulse_reset();
        repeat (500) @(negedge clk);
        chk("mid-sweep ready_o", ready_o, 0);
        pulse_reset();
        wait_ready(1'b0, n);
        chk("restart ready latency", n, 1024);

        // Same-cycle update and lookup on one entry returns the old counter.
        step(1'b1, 32'h40, 1'b1, 10'h010, 1'b1);
        chk("collide idx", pred_idx_o, 10'h010);
        chk("collide taken", pred_taken_o, 0);
        step(1'b1, 32'h44, 1'b0, '0, 1'b0);
        chk("after collide idx", pred_idx_o, 10'h010);
        chk("after collide taken", pred_taken_o, 1);
        chk("after collide ghr", ghr_o, 8'h01);

        pulse_reset();
        wait_ready(1'b0, n);
        chk("third ready latency", n, 1024);

        // History folding into the index.
        step(1'b1, 32'h40, 1'b0, '0, 1'b0);
        chk("pc40 valid", pred_valid_o, 1);
        chk("pc40 idx", pred_idx_o, 10'h010);
        step(1'b0, '0, 1'b1, 10'h010, 1'b1);
        chk("hold valid low", pred_valid_o, 0);
        chk("hold idx", pred_idx_o, 10'h010);
        step(1'b0, '0, 1'b1, 10'h010, 1'b1);
        chk("ghr two taken", ghr_o, 8'h03);
        step(1'b1, 32'h4C, 1'b0, '0, 1'b0);
        chk("pc4c idx", pred_idx_o, 10'h010);
        chk("pc4c taken", pred_taken_o, 1);

        // Saturation at both ends.
        repeat (4) step(1'b0, '0, 1'b1, 10'd5, 1'b1);
        step(1'b0, '0, 1'b1, 10'd5, 1'b0);
        chk("ghr after idx5", ghr_o, 8'h7E);
        step(1'b1, 32'h1EC, 1'b0, '0, 1'b0);
        chk("idx5 idx", pred_idx_o, 10'd5);
        chk("idx5 counter 10", pred_taken_o, 1);
        step(1'b0, '0, 1'b1, 10'd5, 1'b0);
        step(1'b1, 32'h3E4, 1'b0, '0, 1'b0);
        chk("idx5 idx b", pred_idx_o, 10'd5);
        chk("idx5 counter 01", pred_taken_o, 0);
        chk("ghr fc", ghr_o, 8'hFC);
        repeat (5) step(1'b0, '0, 1'b1, 10'd6, 1'b0);
        chk("ghr 80", ghr_o, 8'h80);
        step(1'b1, 32'h218, 1'b0, '0, 1'b0);
        chk("idx6 idx", pred_idx_o, 10'd6);
        chk("idx6 counter 00", pred_taken_o, 0);
        step(1'b0, '0, 1'b1, 10'd6, 1'b1);
        step(1'b1, 32'h1C, 1'b0, '0, 1'b0);
        chk("idx6 idx b", pred_idx_o, 10'd6);
        chk("idx6 counter 01", pred_taken_o, 0);
        chk("ghr 01", ghr_o, 8'h01);

        // Mixed back-to-back traffic on a small index window, checked by the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 63)) << 2,
                 1'($urandom_range(0, 2) != 0), CTB'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter GHR_SIZE, default 8: global history register width in bits.
REQ-002 Parameter COUNTER_TABLE_SZ, default 1024: number of 2-bit pattern counters; COUNTER_TABLE_BITS = log2 of this (10).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ready_o  out  1  high once the table initialisation sweep is complete.
REQ-006 pred_valid_i  in  1  lookup request from fetch.
REQ-007 pred_pc_i  in  32  fetch address being predicted.
REQ-008 pred_valid_o  out  1  lookup result valid, one cycle after the request.
REQ-009 pred_taken_o  out  1  predicted direction, 1 = taken.
REQ-010 pred_idx_o  out  COUNTER_TABLE_BITS  table index used, carried down the pipeline for the later update.
REQ-011 upd_valid_i  in  1  resolved conditional branch from execute.
REQ-012 upd_idx_i  in  COUNTER_TABLE_BITS  index returned from pred_idx_o.
REQ-013 upd_taken_i  in  1  actual branch outcome.
REQ-014 ghr_o  out  GHR_SIZE  current global history, for debug.

Function
REQ-015 The block SHALL have two states: INIT and RUN.
- INIT writes WEAKLY_NOT_TAKEN (2'b01) to one entry per cycle, index 0 to COUNTER_TABLE_SZ-1.
- INIT moves to RUN in the cycle after entry COUNTER_TABLE_SZ-1 is written.
- INIT lasts exactly COUNTER_TABLE_SZ cycles.
REQ-016 ready_o SHALL be 0 in INIT and 1 in RUN.
REQ-017 In INIT, pred_valid_i and upd_valid_i SHALL be ignored, and pred_valid_o SHALL be 0.
REQ-018 Lookup index SHALL be pred_pc_i[COUNTER_TABLE_BITS+1:2] XOR the GHR zero-extended to COUNTER_TABLE_BITS.
REQ-019 Lookup latency SHALL be exactly one cycle. On the edge after pred_valid_i=1 in RUN:
- pred_valid_o is set to 1;
- pred_taken_o is set to counter[1];
- pred_idx_o is set to the index.
pred_valid_o SHALL be 0 in any cycle not preceded by a request.
REQ-020 pred_taken_o and pred_idx_o SHALL hold their last values while pred_valid_o=0.
REQ-021 When upd_valid_i=1 in RUN, the counter at upd_idx_i SHALL be updated as follows:
- incremented when upd_taken_i=1, saturating at STRONGLY_TAKEN (2'b11);
- decremented when upd_taken_i=0, saturating at STRONGLY_NOT_TAKEN (2'b00).
REQ-022 When upd_valid_i=1 in RUN, the GHR SHALL shift left with upd_taken_i entering bit 0. History is non-speculative and updated only at resolve.
REQ-023 Simultaneous lookup and update in the same cycle:
- the lookup uses the pre-update GHR;
- the lookup returns the pre-update counter value, even at the same index (no bypass).
REQ-024 Back-to-back lookups and updates SHALL be accepted every cycle with no stall in RUN.

Reset
REQ-025 When rst=1, the block SHALL enter INIT with sweep index 0, GHR=0, pred_valid_o=0, pred_taken_o=0, pred_idx_o=0 and ready_o=0.
REQ-026 Reset asserted mid-sweep or in RUN SHALL restart the full sweep from index 0.
REQ-027 Counter contents are undefined until the sweep completes.

Structure
REQ-028 The following SHALL live in the shared core package:
- the cntr_pattern_t enum;
- GHR_SIZE, COUNTER_TABLE_SZ, COUNTER_BITS and COUNTER_TABLE_BITS;
- the state enum, as pred_state_t.
REQ-029 The counter table SHALL be a separate sub-module, pht_ram, with:
- one synchronous read port;
- one synchronous write port;
- read-old-data behaviour on a same-address collision.
The INIT writes and the saturating updates SHALL be muxed onto its write port.

Verification
REQ-030 Reset, then hold rst=0 -> ready_o=0 for 1024 cycles, then 1. Lookups at pc 0x0 to 0xFFC all return pred_taken_o=0.
REQ-031 Assert rst at sweep index 500 for one cycle -> ready_o stays 0 for a further 1024 cycles.
REQ-032 With GHR=0, lookup pc=0x40 -> pred_idx_o=0x010 next cycle. Two updates (idx 0x010, taken) -> GHR=0x03, and lookup pc=0x4C returns idx 0x010 (0x013 XOR 0x003) with pred_taken_o=1.
REQ-033 Four taken updates to idx 5 followed by one not-taken -> counter 2'b10 (saturated at 11 first). Five not-taken updates to idx 6 -> counter 2'b00.
REQ-034 In the same cycle, update idx 0x010 (counter 01 -> 10) and lookup that same idx -> pred_taken_o=0. A lookup the next cycle -> pred_taken_o=1.
REQ-035 pred_valid_i and upd_valid_i asserted during INIT -> pred_valid_o stays 0, and GHR stays 0 after the sweep.
